// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and sizes for the memory B-port arbiter
package mem_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  typedef enum logic {ARB, LOCK} arb_state_e;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin picker, ptr names the requester favoured on contention
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_next
);
  always_comb begin
    gnt[0] = req[0] & (~req[1] | ~ptr);
    gnt[1] = req[1] & (~req[0] | ptr);
    ptr_next = &req ? ~ptr : ptr;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of memory port B between the LSU (m0) and the loader/DMA (m1) with m1 lock
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DataWidth = DATA_W,
  parameter int AddrWidth = ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [AddrWidth-1:0] m0_addr,
  input  logic [DataWidth-1:0] m0_wdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [AddrWidth-1:0] m1_addr,
  input  logic [DataWidth-1:0] m1_wdata,
  input  logic                 m1_lock,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [DataWidth-1:0] m0_rdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [DataWidth-1:0] m1_rdata,
  output logic                 mem_readEn,
  output logic                 mem_writeEn,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata
);
  arb_state_e state;
  logic       ptr;
  logic       ptr_next;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic [1:0] rv;
  logic       sel_we;
  rr_arbiter_2 u_rr (
    .req      ({m1_req, m0_req}),
    .ptr      (ptr),
    .gnt      (rr_gnt),
    .ptr_next (ptr_next)
  );
  always_comb begin
    gnt = reset ? 2'b00 : state == LOCK ? {m1_req, 1'b0} : rr_gnt;
    sel_we = gnt[1] ? m1_we : m0_we;
    mem_readEn = (|gnt) & ~sel_we;
    mem_writeEn = (|gnt) & sel_we;
    mem_addr = gnt[1] ? m1_addr : gnt[0] ? m0_addr : '0;
    mem_wdata = gnt[1] ? m1_wdata : gnt[0] ? m0_wdata : '0;
    m0_gnt = gnt[0];
    m1_gnt = gnt[1];
    m0_rvalid = rv[0];
    m1_rvalid = rv[1];
    m0_rdata = rv[0] ? mem_rdata : '0;
    m1_rdata = rv[1] ? mem_rdata : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB;
      ptr <= 1'b0;
      rv <= 2'b00;
    end else begin
      rv <= gnt & {~m1_we, ~m0_we};
      state <= state == LOCK ? (m1_lock ? LOCK : ARB) : (gnt[1] & m1_lock ? LOCK : ARB);
      ptr <= state == LOCK ? (m1_lock & ptr) : ptr_next;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter/memory model
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int DW = 32;
  localparam int AW = 10;
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_readEn, mem_writeEn;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  int n_checks = 0;
  int n_fail = 0;
  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_readEn(mem_readEn), .mem_writeEn(mem_writeEn),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (mem_writeEn) mem[mem_addr] <= mem_wdata;
    if (mem_readEn) mem_rdata <= mem[mem_addr];
  end
  function automatic logic [111:0] all_outs();
    return {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_readEn, mem_writeEn, mem_addr, mem_wdata, m0_rdata, m1_rdata};
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    {m0_req, m0_we, m0_addr, m0_wdata} = '0;
    {m1_req, m1_we, m1_addr, m1_wdata, m1_lock} = '0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge clock);
    n_checks++;
    if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_idle: got %h expected 0", all_outs()); end
    tick();
    m0_req = 1'b1;
    m0_addr = 10'h005;
    @(negedge clock);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_readEn, mem_writeEn} !== 4'b1010) begin
      n_fail++; $display("FAIL reset_first_gnt: got %b expected 1010", {m0_gnt, m1_gnt, mem_readEn, mem_writeEn});
    end
    reset = 1'b1;
    m0_req = 1'b0;
    tick();
    @(negedge clock);
    n_checks++;
    if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_drop_rvalid: got %h expected 0", all_outs()); end
    reset = 1'b0;
    tick();
    @(negedge clock);
    n_checks++;
    if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_after: got %h expected 0", all_outs()); end
    tick();
  endtask
  task automatic test_solo();
    m0_req = 1'b1;
    m0_we = 1'b1;
    m0_addr = 10'h010;
    m0_wdata = 32'hDEADBEEF;
    @(negedge clock);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_readEn, mem_writeEn, mem_addr, mem_wdata} !== {4'b1001, 10'h010, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL solo_write: got %h expected %h", {m0_gnt, m1_gnt, mem_readEn, mem_writeEn, mem_addr, mem_wdata}, {4'b1001, 10'h010, 32'hDEADBEEF});
    end
    tick();
    m0_we = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({m0_gnt, mem_readEn, mem_writeEn, mem_addr, m0_rvalid} !== {3'b110, 10'h010, 1'b0}) begin
      n_fail++; $display("FAIL solo_read_gnt: got %h expected %h", {m0_gnt, mem_readEn, mem_writeEn, mem_addr, m0_rvalid}, {3'b110, 10'h010, 1'b0});
    end
    tick();
    idle();
    @(negedge clock);
    n_checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL solo_read_data: got %h expected %h", {m0_rvalid, m1_rvalid, m0_rdata}, {2'b10, 32'hDEADBEEF});
    end
    tick();
  endtask
  task automatic test_contention();
    logic [1:0]    eg, erv;
    logic [DW-1:0] e0, e1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      m0_req = i < 4;
      m1_req = i < 4;
      m0_addr = 10'h020;
      m1_addr = 10'h030;
      eg = i >= 4 ? 2'b00 : i % 2 == 0 ? 2'b01 : 2'b10;
      erv = i == 0 ? 2'b00 : (i - 1) % 2 == 0 ? 2'b01 : 2'b10;
      e0 = erv[0] ? mem[10'h020] : '0;
      e1 = erv[1] ? mem[10'h030] : '0;
      @(negedge clock);
      n_checks++;
      if ({m1_gnt, m0_gnt} !== eg) begin n_fail++; $display("FAIL contention_gnt[%0d]: got %b expected %b", i, {m1_gnt, m0_gnt}, eg); end
      n_checks++;
      if ({m1_rvalid, m0_rvalid, m1_rdata, m0_rdata} !== {erv, e1, e0}) begin
        n_fail++; $display("FAIL contention_rvalid[%0d]: got %h expected %h", i, {m1_rvalid, m0_rvalid, m1_rdata, m0_rdata}, {erv, e1, e0});
      end
      tick();
    end
    idle();
  endtask
  task automatic test_lock_burst();
    logic [DW-1:0] wd [8];
    for (int i = 0; i < 8; i++) begin
      wd[i] = $urandom;
      m1_req = 1'b1;
      m1_lock = 1'b1;
      m1_we = 1'b1;
      m1_addr = AW'(i);
      m1_wdata = wd[i];
      m0_req = i > 0;
      m0_addr = 10'h040;
      @(negedge clock);
      n_checks++;
      if ({m0_gnt, m1_gnt, mem_writeEn, mem_addr, mem_wdata} !== {3'b011, AW'(i), wd[i]}) begin
        n_fail++; $display("FAIL lock_burst[%0d]: got %h expected %h", i, {m0_gnt, m1_gnt, mem_writeEn, mem_addr, mem_wdata}, {3'b011, AW'(i), wd[i]});
      end
      tick();
    end
    {m1_req, m1_lock, m1_we} = '0;
    @(negedge clock);
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL lock_release_blocked: got %b expected 00", {m0_gnt, m1_gnt}); end
    tick();
    @(negedge clock);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_readEn, mem_addr} !== {3'b101, 10'h040}) begin
      n_fail++; $display("FAIL lock_release_m0: got %h expected %h", {m0_gnt, m1_gnt, mem_readEn, mem_addr}, {3'b101, 10'h040});
    end
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem[i] !== wd[i]) begin n_fail++; $display("FAIL lock_burst_mem[%0d]: got %h expected %h", i, mem[i], wd[i]); end
    end
    tick();
  endtask
  task automatic test_lock_idle();
    m1_req = 1'b1;
    m1_lock = 1'b1;
    m1_addr = 10'h005;
    @(negedge clock);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_readEn} !== 3'b011) begin n_fail++; $display("FAIL lock_idle_enter: got %b expected 011", {m0_gnt, m1_gnt, mem_readEn}); end
    tick();
    m1_req = 1'b0;
    m0_req = 1'b1;
    m0_addr = 10'h050;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if ({m0_gnt, m1_gnt, mem_readEn, mem_writeEn, m1_rvalid} !== {4'b0000, i == 0}) begin
        n_fail++; $display("FAIL lock_idle[%0d]: got %b expected %b", i, {m0_gnt, m1_gnt, mem_readEn, mem_writeEn, m1_rvalid}, {4'b0000, i == 0});
      end
      tick();
    end
    m1_lock = 1'b0;
    @(negedge clock);
    n_checks++;
    if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_idle_release: got %b expected 0", m0_gnt); end
    tick();
    @(negedge clock);
    n_checks++;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_idle_m0: got %b expected 1", m0_gnt); end
    tick();
    idle();
    tick();
  endtask
  task automatic test_back_to_back();
    m0_req = 1'b1;
    m0_addr = 10'h3FF;
    @(negedge clock);
    n_checks++;
    if ({m0_gnt, mem_readEn, mem_addr} !== {2'b11, 10'h3FF}) begin
      n_fail++; $display("FAIL b2b_first: got %h expected %h", {m0_gnt, mem_readEn, mem_addr}, {2'b11, 10'h3FF});
    end
    tick();
    m0_addr = 10'h000;
    @(negedge clock);
    n_checks++;
    if ({m0_gnt, mem_readEn, mem_addr, m0_rvalid, m0_rdata} !== {2'b11, 10'h000, 1'b1, mem[10'h3FF]}) begin
      n_fail++; $display("FAIL b2b_second: got %h expected %h", {m0_gnt, mem_readEn, mem_addr, m0_rvalid, m0_rdata}, {2'b11, 10'h000, 1'b1, mem[10'h3FF]});
    end
    tick();
    idle();
    @(negedge clock);
    n_checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, mem[10'h000]}) begin
      n_fail++; $display("FAIL b2b_third: got %h expected %h", {m0_rvalid, m0_rdata}, {1'b1, mem[10'h000]});
    end
    tick();
  endtask
  task automatic test_random();
    mem_req_t      r0, r1, ew;
    logic          h0, h1, lk, locked, ptr, both;
    logic [1:0]    eg, erv;
    logic [DW-1:0] erd0, erd1;
    do_reset();
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = mem[i];
    {h0, h1, lk, locked, ptr, erv, erd0, erd1} = '0;
    r0 = '0;
    r1 = '0;
    for (int c = 0; c < 400; c++) begin
      if (!h0 && $urandom_range(0, 2) != 0) begin
        h0 = 1'b1; r0.we = 1'($urandom_range(0, 1)); r0.addr = AW'($urandom_range(0, 15)); r0.wdata = $urandom;
      end
      if (!h1 && $urandom_range(0, 2) != 0) begin
        h1 = 1'b1; r1.we = 1'($urandom_range(0, 1)); r1.addr = AW'($urandom_range(0, 15)); r1.wdata = $urandom;
      end
      if ($urandom_range(0, 5) == 0) lk = ~lk;
      m0_req = h0;
      m1_req = h1;
      {m0_we, m0_addr, m0_wdata} = r0;
      {m1_we, m1_addr, m1_wdata} = r1;
      m1_lock = lk;
      both = h0 & h1;
      if (locked) eg = {h1, 1'b0};
      else if (both) eg = ptr ? 2'b10 : 2'b01;
      else eg = {h1, h0};
      ew = eg[1] ? r1 : eg[0] ? r0 : '0;
      @(negedge clock);
      n_checks++;
      if ({m1_gnt, m0_gnt, mem_readEn, mem_writeEn, mem_addr, mem_wdata} !== {eg, (|eg) & !ew.we, (|eg) & ew.we, ew.addr, ew.wdata}) begin
        n_fail++; $display("FAIL rand_gnt[%0d]: got %h expected %h", c, {m1_gnt, m0_gnt, mem_readEn, mem_writeEn, mem_addr, mem_wdata}, {eg, (|eg) & !ew.we, (|eg) & ew.we, ew.addr, ew.wdata});
      end
      n_checks++;
      if ({m1_rvalid, m0_rvalid, m1_rdata, m0_rdata} !== {erv, erd1, erd0}) begin
        n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h", c, {m1_rvalid, m0_rvalid, m1_rdata, m0_rdata}, {erv, erd1, erd0});
      end
      erv = '0;
      erd0 = '0;
      erd1 = '0;
      if (eg[0]) begin
        if (r0.we) ref_mem[r0.addr] = r0.wdata;
        else begin erv[0] = 1'b1; erd0 = ref_mem[r0.addr]; end
        h0 = 1'b0;
      end
      if (eg[1]) begin
        if (r1.we) ref_mem[r1.addr] = r1.wdata;
        else begin erv[1] = 1'b1; erd1 = ref_mem[r1.addr]; end
        h1 = 1'b0;
      end
      if (locked) begin
        if (!lk) begin locked = 1'b0; ptr = 1'b0; end
      end else begin
        if (both) ptr = ~ptr;
        if (eg[1] && lk) locked = 1'b1;
      end
      tick();
    end
    idle();
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    idle();
    test_reset();
    test_solo();
    test_contention();
    test_lock_burst();
    test_lock_idle();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
